// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: WIDTH-bit words in over valid/ready, one bit out per enabled clock.
// Latency: first bit on sout one cycle after accept; each word holds sout_valid for WIDTH enabled cycles.
// Backpressure: din_ready only when idle or on a word's last bit; enable=0 stalls everything.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic             r_sout;
    logic             w_sout_nxt;
    logic             r_sout_valid;
    logic             w_sout_valid_nxt;
    logic             w_at_last;
    logic             w_accept;

    assign w_at_last = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
    assign din_ready = !rst && enable && ((r_state == S_IDLE) || w_at_last);
    assign w_accept  = din_valid && din_ready;

    // The shift register rotates so the bit after the one on sout always sits at a fixed index.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shreg_nxt      = r_shreg;
        w_sout_nxt       = r_sout;
        w_sout_valid_nxt = r_sout_valid;
        if (enable) begin
            if (w_accept) begin
                w_state_nxt      = S_SHIFT;
                w_shreg_nxt      = din;
                w_cnt_nxt        = '0;
                w_sout_nxt       = MSB_FIRST ? din[WIDTH-1] : din[0];
                w_sout_valid_nxt = 1'b1;
            end else if (r_state == S_SHIFT && !w_at_last) begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (MSB_FIRST) begin
                    w_shreg_nxt = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
                    w_sout_nxt  = r_shreg[WIDTH-2];
                end else begin
                    w_shreg_nxt = {r_shreg[0], r_shreg[WIDTH-1:1]};
                    w_sout_nxt  = r_shreg[1];
                end
            end else begin
                w_state_nxt      = S_IDLE;
                w_cnt_nxt        = '0;
                w_sout_nxt       = IDLE_BIT;
                w_sout_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shreg      <= '0;
            r_sout       <= IDLE_BIT;
            r_sout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shreg      <= w_shreg_nxt;
            r_sout       <= w_sout_nxt;
            r_sout_valid <= w_sout_valid_nxt;
        end
    end

    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign last_bit   = w_at_last;
    assign busy       = (r_state == S_SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: queue-based reference model on an 8-bit MSB-first instance,
// directed checks on an LSB-first instance and a 4-bit instance feeding a 1010 detector model.
module tb_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Instance A: WIDTH=8, MSB first, idle 0
    logic       a_rst = 1'b1, a_en = 1'b0, a_vld = 1'b0;
    logic [7:0] a_din = '0;
    logic       a_rdy, a_sout, a_sv, a_last, a_busy;
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
        .clk(clk), .rst(a_rst), .enable(a_en), .din(a_din), .din_valid(a_vld),
        .din_ready(a_rdy), .sout(a_sout), .sout_valid(a_sv), .last_bit(a_last), .busy(a_busy));

    // Instance B: WIDTH=8, LSB first, idle 1
    logic       b_rst = 1'b1, b_en = 1'b1, b_vld = 1'b0;
    logic [7:0] b_din = '0;
    logic       b_rdy, b_sout, b_sv, b_last, b_busy;
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_b (
        .clk(clk), .rst(b_rst), .enable(b_en), .din(b_din), .din_valid(b_vld),
        .din_ready(b_rdy), .sout(b_sout), .sout_valid(b_sv), .last_bit(b_last), .busy(b_busy));

    // Instance C: WIDTH=4, MSB first, feeds the detector model
    logic       c_rst = 1'b1, c_en = 1'b1, c_vld = 1'b0;
    logic [3:0] c_din = '0;
    logic       c_rdy, c_sout, c_sv, c_last, c_busy;
    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_c (
        .clk(clk), .rst(c_rst), .enable(c_en), .din(c_din), .din_valid(c_vld),
        .din_ready(c_rdy), .sout(c_sout), .sout_valid(c_sv), .last_bit(c_last), .busy(c_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model for A: bits still owed after the one currently on sout.
    bit q[$];
    bit m_sout = 1'b0;
    bit m_sv   = 1'b0;
    bit last_rdy;

    function automatic bit m_ready(input bit r, input bit e);
        return !r && e && (!m_sv || q.size() == 0);
    endfunction

    task automatic a_step(input bit r, input bit e, input bit v, input logic [7:0] d);
        bit acc;
        a_rst = r; a_en = e; a_vld = v; a_din = d;
        #1;
        last_rdy = m_ready(r, e);
        chk("a_din_ready", {31'b0, a_rdy}, {31'b0, last_rdy});
        acc = v && last_rdy;
        @(posedge clk); #1;
        if (r) begin
            q.delete();
            m_sv = 1'b0; m_sout = 1'b0;
        end else if (e) begin
            if (acc)
                for (int i = 7; i >= 0; i--) q.push_back(d[i]);
            if (q.size() > 0) begin
                m_sout = q.pop_front(); m_sv = 1'b1;
            end else begin
                m_sout = 1'b0; m_sv = 1'b0;
            end
        end
        chk("a_sout",       {31'b0, a_sout}, {31'b0, m_sout});
        chk("a_sout_valid", {31'b0, a_sv},   {31'b0, m_sv});
        chk("a_last_bit",   {31'b0, a_last}, {31'b0, (m_sv && q.size() == 0)});
        chk("a_busy",       {31'b0, a_busy}, {31'b0, m_sv});
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0]  vec;
        logic [15:0] rdyvec;
        int          svcnt;
        int          wi;
        int          nbits;
        int          det;
        int          det8;
        logic [3:0]  win;
        logic [3:0]  words [3];
        bit          acc;

        #1;
        // Reset state, then 8'hA5 offered for one cycle
        for (int i = 0; i < 3; i++) a_step(1'b1, 1'b1, 1'b1, 8'hFF);
        chk("t1_rst_sout", {31'b0, a_sout}, 32'd0);
        vec = '0;
        a_step(1'b0, 1'b1, 1'b1, 8'hA5);
        vec = {vec[6:0], a_sout};
        for (int i = 0; i < 7; i++) begin
            a_step(1'b0, 1'b1, 1'b0, 8'h00);
            vec = {vec[6:0], a_sout};
        end
        chk("t1_bits", {24'b0, vec}, 32'hA5);
        chk("t1_last_on_8", {31'b0, a_last}, 32'd1);
        a_step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t1_idle_valid", {31'b0, a_sv}, 32'd0);

        // Back-to-back A5 then 3C
        rdyvec = '0; svcnt = 0;
        for (int i = 0; i < 16; i++) begin
            a_step(1'b0, 1'b1, (i <= 8), (i < 8) ? 8'hA5 : 8'h3C);
            rdyvec[i] = last_rdy;
            svcnt += int'(a_sv);
        end
        chk("t2_ready_pattern", {16'b0, rdyvec}, 32'h0101);
        chk("t2_contig_valid", svcnt, 32'd16);
        a_step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t2_gap_after", {31'b0, a_sv}, 32'd0);

        // Two-cycle stall mid-word
        a_step(1'b0, 1'b1, 1'b1, 8'hF0);
        a_step(1'b0, 1'b1, 1'b0, 8'h00);
        a_step(1'b0, 1'b1, 1'b0, 8'h00);
        a_step(1'b0, 1'b0, 1'b1, 8'h55);
        chk("t3_stall_hold", {31'b0, a_sout}, 32'd1);
        a_step(1'b0, 1'b0, 1'b1, 8'h55);
        for (int i = 0; i < 5; i++) a_step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t3_last_on_10", {31'b0, a_last}, 32'd1);
        a_step(1'b0, 1'b1, 1'b0, 8'h00);

        // Reset mid-word, then a fresh word
        a_step(1'b0, 1'b1, 1'b1, 8'hC3);
        a_step(1'b0, 1'b1, 1'b0, 8'h00);
        a_step(1'b0, 1'b1, 1'b0, 8'h00);
        a_step(1'b1, 1'b1, 1'b0, 8'h00);
        chk("t4_rst_valid", {31'b0, a_sv}, 32'd0);
        chk("t4_rst_busy", {31'b0, a_busy}, 32'd0);
        vec = '0;
        a_step(1'b0, 1'b1, 1'b1, 8'h81);
        vec = {vec[6:0], a_sout};
        for (int i = 0; i < 7; i++) begin
            a_step(1'b0, 1'b1, 1'b0, 8'h00);
            vec = {vec[6:0], a_sout};
        end
        chk("t4_bits", {24'b0, vec}, 32'h81);

        // Randomized traffic against the queue model
        for (int i = 0; i < 800; i++)
            a_step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85),
                   ($urandom_range(0, 99) < 60), 8'($urandom));

        // LSB-first instance, idle bit 1
        tick(); tick();
        b_rst = 1'b1; b_vld = 1'b1; b_din = 8'h0A;
        #1;
        chk("t5_rdy_in_rst", {31'b0, b_rdy}, 32'd0);
        tick();
        chk("t5_rst_wins_valid", {31'b0, b_sv}, 32'd0);
        chk("t5_rst_wins_sout", {31'b0, b_sout}, 32'd1);
        b_rst = 1'b0;
        #1;
        chk("t5_rdy", {31'b0, b_rdy}, 32'd1);
        tick();
        b_vld = 1'b0; b_din = 8'hFF;
        vec = '0;
        vec[0] = b_sout;
        for (int i = 1; i < 8; i++) begin
            tick();
            vec[i] = b_sout;
        end
        chk("t5_lsb_bits", {24'b0, vec}, 32'h0A);
        chk("t5_last", {31'b0, b_last}, 32'd1);
        tick();
        chk("t5_idle_sout", {31'b0, b_sout}, 32'd1);
        chk("t5_idle_busy", {31'b0, b_busy}, 32'd0);

        // WIDTH=4 stream into a 1010 detector model
        words[0] = 4'b1010; words[1] = 4'b1010; words[2] = 4'b1111;
        tick(); tick();
        c_rst = 1'b0;
        wi = 0; nbits = 0; det = 0; det8 = -1; win = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            c_vld = (wi < 3);
            c_din = (wi < 3) ? words[wi] : 4'b0000;
            #1;
            acc = c_vld && c_rdy;
            tick();
            if (acc) wi++;
            if (c_sv) begin
                win = {win[2:0], c_sout};
                nbits++;
                if (nbits >= 4 && win == 4'b1010) det++;
                if (nbits == 8) det8 = det;
            end
        end
        chk("t6_all_accepted", wi, 32'd3);
        chk("t6_bits_total", nbits, 32'd12);
        chk("t6_det_twice", {31'b0, (det8 >= 2)}, 32'd1);
        chk("t6_no_det_1111", det, det8);
        chk("t6_idle_end", {30'b0, c_busy, c_last}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
